// File: rtl/lmac_pkg.sv
// Shared types and constants for the loopback/host TX arbiter.
package lmac_pkg;

  // One-hot arbiter states
  typedef enum logic [3:0] {
    ST_IDLE = 4'h1,
    ST_HDR  = 4'h2,
    ST_DATA = 4'h4,
    ST_GAP  = 4'h8
  } arb_state_e;

  // arb_mode encodings
  localparam logic [1:0] MODE_HOST = 2'd0;
  localparam logic [1:0] MODE_LPBK = 2'd1;
  localparam logic [1:0] MODE_RR   = 2'd2;
  localparam logic [1:0] MODE_LPRI = 2'd3;

  // Source select encodings (arb_src / RR pointer)
  localparam logic SRC_HOST = 1'b0;
  localparam logic SRC_LPBK = 1'b1;

  // Byte count field inside the header qword
  localparam int BCNT_MSB = 15;
  localparam int BCNT_LSB = 0;

  localparam int QW_CNT_W = 14;

  // Data qwords following a header: ceil(bcnt/8), summed in 17 bits so
  // bcnt near 16'hFFFF does not wrap.
  function automatic logic [QW_CNT_W-1:0] bcnt_to_qw(input logic [15:0] bcnt);
    logic [16:0] sum;
    sum = {1'b0, bcnt} + 17'd7;
    return sum[16:3];
  endfunction

endpackage

// File: rtl/lpbk_tx_arb_if.sv
// Bus bundle between the arbiter, its two source FIFOs and the TX MAC FIFO.
interface lpbk_tx_arb_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       arb_mode;
  logic [63:0]      hst_data;
  logic             hst_empty;
  logic             hst_rd;
  logic [63:0]      lpb_data;
  logic             lpb_empty;
  logic             lpb_rd;
  logic             tx_mac_wr;
  logic [63:0]      tx_mac_data;
  logic             tx_mac_full;
  logic [12:0]      tx_mac_usedw;
  logic             arb_busy;
  logic             arb_src;
  logic [CNT_W-1:0] hst_pkt_cnt;
  logic [CNT_W-1:0] lpb_pkt_cnt;

  // Arbiter side
  modport master (
    input  arb_mode, hst_data, hst_empty, lpb_data, lpb_empty,
           tx_mac_full, tx_mac_usedw,
    output hst_rd, lpb_rd, tx_mac_wr, tx_mac_data, arb_busy, arb_src,
           hst_pkt_cnt, lpb_pkt_cnt
  );

  // FIFO / environment side
  modport slave (
    output arb_mode, hst_data, hst_empty, lpb_data, lpb_empty,
           tx_mac_full, tx_mac_usedw,
    input  hst_rd, lpb_rd, tx_mac_wr, tx_mac_data, arb_busy, arb_src,
           hst_pkt_cnt, lpb_pkt_cnt
  );
endinterface

// File: rtl/lpbk_tx_arb_sel.sv
// Combinational grant logic: picks the next packet source from mode,
// FIFO emptiness and the round-robin pointer.
module lpbk_tx_arb_sel
  import lmac_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       hst_empty,
  input  logic       lpb_empty,
  input  logic       rr_ptr,
  output logic       grant_valid,
  output logic       grant_src
);

  // Grant decode per arbitration mode
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_HOST;
    case (mode)
      MODE_HOST: begin
        grant_valid = !hst_empty;
        grant_src   = SRC_HOST;
      end
      MODE_LPBK: begin
        grant_valid = !lpb_empty;
        grant_src   = SRC_LPBK;
      end
      MODE_RR: begin
        grant_valid = !hst_empty || !lpb_empty;
        // Pointer only matters when both sides have a packet waiting
        grant_src   = (!hst_empty && !lpb_empty) ? rr_ptr : hst_empty;
      end
      MODE_LPRI: begin
        grant_valid = !hst_empty || !lpb_empty;
        grant_src   = !lpb_empty;
      end
      default: begin
        grant_valid = 1'b0;
        grant_src   = SRC_HOST;
      end
    endcase
  end

endmodule

// File: rtl/lpbk_tx_arb.sv
// Packet-granular arbiter sharing the TX MAC FIFO write port between the
// host and loopback streams. Whole packets only, never interleaved.
module lpbk_tx_arb
  import lmac_pkg::*;
#(
  parameter logic [12:0] USEDW_THR = 13'h300,
  parameter int          CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  lpbk_tx_arb_if.master bus
);

  arb_state_e            state_q, state_d;
  logic                  src_q, src_d;
  logic                  rr_q, rr_d;
  logic [1:0]            mode_q, mode_d;
  logic [QW_CNT_W-1:0]   qw_cnt_q, qw_cnt_d;
  logic                  wr_q, wr_d;
  logic [63:0]           data_q, data_d;
  logic [CNT_W-1:0]      hcnt_q, hcnt_d;
  logic [CNT_W-1:0]      lcnt_q, lcnt_d;

  logic                  grant_valid;
  logic                  grant_src;
  logic                  sel_empty;
  logic [63:0]           sel_data;
  logic                  pop;

  lpbk_tx_arb_sel u_sel (
    .mode        (bus.arb_mode),
    .hst_empty   (bus.hst_empty),
    .lpb_empty   (bus.lpb_empty),
    .rr_ptr      (rr_q),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  assign sel_empty = (src_q == SRC_LPBK) ? bus.lpb_empty : bus.hst_empty;
  assign sel_data  = (src_q == SRC_LPBK) ? bus.lpb_data  : bus.hst_data;

  // A qword moves when a transfer state has data and room downstream;
  // reset blocks it so an aborted packet loses nothing further upstream.
  assign pop = ((state_q == ST_HDR) || (state_q == ST_DATA)) &&
               !sel_empty && !bus.tx_mac_full && !reset;

  assign bus.hst_rd      = pop && (src_q == SRC_HOST);
  assign bus.lpb_rd      = pop && (src_q == SRC_LPBK);
  assign bus.tx_mac_wr   = wr_q;
  assign bus.tx_mac_data = data_q;
  assign bus.arb_busy    = (state_q != ST_IDLE);
  assign bus.arb_src     = src_q;
  assign bus.hst_pkt_cnt = hcnt_q;
  assign bus.lpb_pkt_cnt = lcnt_q;

  // Next-state, qword counter, packet counters and write-register inputs
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    rr_d     = rr_q;
    mode_d   = mode_q;
    qw_cnt_d = qw_cnt_q;
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    wr_d     = pop;
    data_d   = pop ? sel_data : data_q;

    case (state_q)
      ST_IDLE: begin
        if (!bus.tx_mac_full && (bus.tx_mac_usedw <= USEDW_THR) && grant_valid) begin
          state_d = ST_HDR;
          src_d   = grant_src;
          mode_d  = bus.arb_mode;
        end
      end
      ST_HDR: begin
        if (pop) begin
          qw_cnt_d = bcnt_to_qw(sel_data[BCNT_MSB:BCNT_LSB]);
          if (src_q == SRC_LPBK) lcnt_d = lcnt_q + 1'b1;
          else                   hcnt_d = hcnt_q + 1'b1;
          state_d = (qw_cnt_d == '0) ? ST_GAP : ST_DATA;
        end
      end
      ST_DATA: begin
        if (pop) begin
          qw_cnt_d = qw_cnt_q - 1'b1;
          if (qw_cnt_q == QW_CNT_W'(1)) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // Mode captured at grant time decides pointer movement
        if (mode_q == MODE_RR) rr_d = ~src_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_HOST;
      rr_q     <= SRC_HOST;
      mode_q   <= MODE_HOST;
      qw_cnt_q <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      rr_q     <= rr_d;
      mode_q   <= mode_d;
      qw_cnt_q <= qw_cnt_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
    end
  end

endmodule

// File: tb/tb_lpbk_tx_arb.sv
// Bench for lpbk_tx_arb: show-ahead FIFO models on both sources, a capture
// queue on the TX MAC side and a packet-level ordering model.
module tb_lpbk_tx_arb;
  import lmac_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lpbk_tx_arb_if #(.CNT_W(16)) bus();

  lpbk_tx_arb #(.USEDW_THR(13'h300), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] hq[$], lq[$];         // FIFO contents
  logic [63:0] mh[$], ml[$];         // packet words per source, for the model
  int          mhl[$], mll[$];       // packet lengths in qwords
  logic [63:0] wq[$];                // captured TX MAC writes
  int          wcyc[$];
  int          cyc = 0;
  int          hpops = 0, lpops = 0;
  bit          hpop, lpop;
  bit          rnd_stall = 0;

  typedef struct {
    logic [1:0]  mode;
    logic        h;
    logic        l;
    logic [12:0] usedw;
    logic        exp_busy;
    logic        exp_src;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    bus.hst_empty = (hq.size() == 0);
    bus.hst_data  = (hq.size() != 0) ? hq[0] : 64'd0;
    bus.lpb_empty = (lq.size() == 0);
    bus.lpb_data  = (lq.size() != 0) ? lq[0] : 64'd0;
  endtask

  // Observe pops and writes at the active edge
  always @(posedge clk) begin
    cyc++;
    hpop = bus.hst_rd;
    lpop = bus.lpb_rd;
    if (hpop) hpops++;
    if (lpop) lpops++;
    if (bus.tx_mac_wr) begin
      wq.push_back(bus.tx_mac_data);
      wcyc.push_back(cyc);
    end
  end

  // Apply pops to the FIFO models away from the edge
  always @(negedge clk) begin
    if (hpop && hq.size() > 0) void'(hq.pop_front());
    if (lpop && lq.size() > 0) void'(lq.pop_front());
    if (rnd_stall) begin
      bus.tx_mac_full  = ($urandom_range(0, 3) == 0);
      bus.tx_mac_usedw = ($urandom_range(0, 4) == 0) ? 13'h301 + 13'($urandom_range(0, 7))
                                                    : 13'($urandom_range(0, 'h300));
    end
    refresh();
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rnd_stall = 0;
    hq.delete(); lq.delete(); mh.delete(); ml.delete();
    mhl.delete(); mll.delete();
    bus.tx_mac_full  = 1'b0;
    bus.tx_mac_usedw = 13'd0;
    refresh();
    repeat (2) @(negedge clk);
    wq.delete(); wcyc.delete();
    hpops = 0; lpops = 0;
    reset = 1'b0;
  endtask

  task automatic push_pkt(bit src, logic [15:0] bcnt);
    logic [63:0] w;
    int nqw;
    nqw = (int'(bcnt) + 7) / 8;
    w = {$urandom, $urandom};
    w[15:0] = bcnt;
    for (int j = 0; j <= nqw; j++) begin
      if (j > 0) w = {$urandom, $urandom};
      if (src) begin lq.push_back(w); ml.push_back(w); end
      else     begin hq.push_back(w); mh.push_back(w); end
    end
    if (src) mll.push_back(nqw + 1);
    else     mhl.push_back(nqw + 1);
    refresh();
  endtask

  task automatic wait_pops(bit src, int n, string nm);
    int t = 0;
    while (((src ? lpops : hpops) < n) && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: pop wait timed out, got %0d pops expected %0d", nm, src ? lpops : hpops, n);
    end
  endtask

  task automatic wait_done(int nexp, string nm);
    int t = 0;
    while ((wq.size() < nexp || bus.arb_busy) && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: transfer timed out, got %0d writes expected %0d", nm, wq.size(), nexp);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic cmp_stream(string nm, input logic [63:0] e[$]);
    chk({nm, " write count"}, 64'(wq.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < wq.size(); i++)
      chk($sformatf("%s qword %0d", nm, i), wq[i], e[i]);
  endtask

  // Packet-level ordering model: walk the queued packets, choose a source at
  // every packet boundary by the mode's rule, emit whole packets.
  task automatic build_exp(input logic [1:0] mode, output logic [63:0] e[$],
                           output int nhs, output int nls);
    int hi = 0, li = 0, ho = 0, lo = 0;
    bit rr = 0, hav, lav, s;
    e.delete(); nhs = 0; nls = 0;
    forever begin
      hav = (mode != MODE_LPBK) && (hi < mhl.size());
      lav = (mode != MODE_HOST) && (li < mll.size());
      if (!hav && !lav) break;
      s = (mode == MODE_RR && hav && lav) ? rr : lav;
      if (s) begin
        for (int j = 0; j < mll[li]; j++) e.push_back(ml[lo + j]);
        lo += mll[li]; li++; nls++;
      end else begin
        for (int j = 0; j < mhl[hi]; j++) e.push_back(mh[ho + j]);
        ho += mhl[hi]; hi++; nhs++;
      end
      if (mode == MODE_RR) rr = !s;
    end
  endtask

  task automatic run_model(string nm);
    logic [63:0] e[$];
    int nhs, nls;
    build_exp(bus.arb_mode, e, nhs, nls);
    wait_done(e.size(), nm);
    cmp_stream(nm, e);
    chk({nm, " hst_pkt_cnt"}, 64'(bus.hst_pkt_cnt), 64'(nhs));
    chk({nm, " lpb_pkt_cnt"}, 64'(bus.lpb_pkt_cnt), 64'(nls));
  endtask

  initial begin
    logic [63:0] e[$];
    int p, w;

    tbl[0] = '{MODE_HOST, 1'b1, 1'b1, 13'h000, 1'b1, 1'b0};
    tbl[1] = '{MODE_HOST, 1'b0, 1'b1, 13'h000, 1'b0, 1'b0};
    tbl[2] = '{MODE_LPBK, 1'b1, 1'b1, 13'h000, 1'b1, 1'b1};
    tbl[3] = '{MODE_LPBK, 1'b1, 1'b0, 13'h000, 1'b0, 1'b0};
    tbl[4] = '{MODE_RR,   1'b1, 1'b1, 13'h000, 1'b1, 1'b0};
    tbl[5] = '{MODE_RR,   1'b0, 1'b1, 13'h000, 1'b1, 1'b1};
    tbl[6] = '{MODE_LPRI, 1'b1, 1'b1, 13'h000, 1'b1, 1'b1};
    tbl[7] = '{MODE_LPRI, 1'b1, 1'b0, 13'h000, 1'b1, 1'b0};
    tbl[8] = '{MODE_LPRI, 1'b1, 1'b1, 13'h301, 1'b0, 1'b0};
    tbl[9] = '{MODE_RR,   1'b1, 1'b1, 13'h300, 1'b1, 1'b0};

    bus.arb_mode = MODE_HOST;
    bus.tx_mac_full = 1'b0;
    bus.tx_mac_usedw = 13'd0;
    refresh();
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset tx_mac_wr",   64'(bus.tx_mac_wr), 0);
    chk("reset tx_mac_data", bus.tx_mac_data, 0);
    chk("reset arb_busy",    64'(bus.arb_busy), 0);
    chk("reset arb_src",     64'(bus.arb_src), 0);
    chk("reset hst_pkt_cnt", 64'(bus.hst_pkt_cnt), 0);
    chk("reset lpb_pkt_cnt", 64'(bus.lpb_pkt_cnt), 0);

    // Grant decisions from a fresh reset
    for (int i = 0; i < 10; i++) begin
      do_reset();
      bus.arb_mode = tbl[i].mode;
      bus.tx_mac_usedw = tbl[i].usedw;
      if (tbl[i].h) push_pkt(0, 16'd8);
      if (tbl[i].l) push_pkt(1, 16'd8);
      @(negedge clk);
      chk($sformatf("vec%0d arb_busy", i), 64'(bus.arb_busy), 64'(tbl[i].exp_busy));
      if (tbl[i].exp_busy)
        chk($sformatf("vec%0d arb_src", i), 64'(bus.arb_src), 64'(tbl[i].exp_src));
    end

    // Round-robin with two packets each side: H,L,H,L with idle gaps
    do_reset();
    bus.arb_mode = MODE_RR;
    push_pkt(0, 16'd16); push_pkt(0, 16'd16);
    push_pkt(1, 16'd16); push_pkt(1, 16'd16);
    run_model("rr");
    if (wcyc.size() == 12) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr pkt%0d back-to-back", k), 64'(wcyc[3*k+2] - wcyc[3*k]), 2);
        if (k > 0)
          chk($sformatf("rr pkt%0d idle gap", k), 64'(wcyc[3*k] - wcyc[3*k-1] >= 3), 1);
      end
    end

    // Loopback priority: loopback arrives mid host packet, waits for its end,
    // then wins over the next queued host packet
    do_reset();
    bus.arb_mode = MODE_LPRI;
    push_pkt(0, 16'd24);
    push_pkt(0, 16'd8);
    wait_pops(0, 1, "lpri host hdr");
    push_pkt(1, 16'd60);
    wait_pops(1, 1, "lpri lpb hdr");
    chk("lpri arb_src", 64'(bus.arb_src), 1);
    e.delete();
    for (int i = 0; i < 4; i++) e.push_back(mh[i]);
    for (int i = 0; i < 9; i++) e.push_back(ml[i]);
    for (int i = 4; i < 6; i++) e.push_back(mh[i]);
    wait_done(15, "lpri");
    cmp_stream("lpri", e);

    // Back-pressure: full for 4 cycles after the 2nd data pop
    do_reset();
    bus.arb_mode = MODE_LPBK;
    push_pkt(1, 16'd20);
    wait_pops(1, 3, "stall");
    bus.tx_mac_full = 1'b1;
    p = lpops; w = wq.size();
    repeat (4) @(negedge clk);
    chk("stall no pops", 64'(lpops), 64'(p));
    chk("stall writes", 64'(wq.size()), 64'(w + 1));
    bus.tx_mac_full = 1'b0;
    e = ml;
    wait_done(4, "stall");
    cmp_stream("stall", e);

    // usedw threshold boundary
    do_reset();
    bus.arb_mode = MODE_RR;
    bus.tx_mac_usedw = 13'h301;
    push_pkt(0, 16'd8); push_pkt(1, 16'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("usedw hold busy %0d", i), 64'(bus.arb_busy), 0);
    end
    bus.tx_mac_usedw = 13'h300;
    @(negedge clk);
    chk("usedw thr busy", 64'(bus.arb_busy), 1);

    // Zero-length packet: header only, HDR -> GAP -> IDLE
    do_reset();
    bus.arb_mode = MODE_LPBK;
    push_pkt(1, 16'd0);
    e = ml;
    @(negedge clk);
    chk("bcnt0 hdr busy", 64'(bus.arb_busy), 1);
    @(negedge clk);
    chk("bcnt0 gap busy", 64'(bus.arb_busy), 1);
    chk("bcnt0 lpb_pkt_cnt", 64'(bus.lpb_pkt_cnt), 1);
    @(negedge clk);
    chk("bcnt0 idle busy", 64'(bus.arb_busy), 0);
    repeat (3) @(negedge clk);
    cmp_stream("bcnt0", e);

    // Reset during DATA with 5 qwords left
    do_reset();
    bus.arb_mode = MODE_LPBK;
    push_pkt(1, 16'd80);
    wait_pops(1, 6, "rstmid");
    reset = 1'b1;
    p = lpops;
    @(negedge clk);
    chk("rstmid arb_busy",    64'(bus.arb_busy), 0);
    chk("rstmid tx_mac_wr",   64'(bus.tx_mac_wr), 0);
    chk("rstmid tx_mac_data", bus.tx_mac_data, 0);
    chk("rstmid arb_src",     64'(bus.arb_src), 0);
    chk("rstmid lpb_pkt_cnt", 64'(bus.lpb_pkt_cnt), 0);
    @(negedge clk);
    bus.arb_mode = MODE_HOST;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid no pops", 64'(lpops), 64'(p));
    chk("rstmid idle", 64'(bus.arb_busy), 0);

    // Randomized packets, modes and back-pressure against the packet model
    for (int it = 0; it < 20; it++) begin
      int nh, nl;
      do_reset();
      bus.arb_mode = 2'($urandom_range(0, 3));
      nh = $urandom_range(0, 3);
      nl = $urandom_range(0, 3);
      for (int k = 0; k < nh; k++) push_pkt(0, 16'($urandom_range(0, 70)));
      for (int k = 0; k < nl; k++) push_pkt(1, 16'($urandom_range(0, 70)));
      rnd_stall = 1;
      run_model($sformatf("rand%0d", it));
      rnd_stall = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lpbk_tx_arb.md
Name: lpbk_tx_arb

Overview:
Packet-granular arbiter that shares the TX MAC FIFO write port between the host transmit stream and the loopback stream. Each source is a show-ahead FIFO carrying packets in the TX MAC format: one header qword with byte count in [15:0], then ceil(bcnt/8) data qwords. The block selects a source, then moves one whole packet into the TX MAC FIFO under full/usedw back-pressure. It never interleaves packets. A 2-bit mode input selects host-only, loopback-only, round-robin or loopback-priority.

Parameters:
USEDW_THR, 13'h300, start a packet only if tx_mac_usedw <= USEDW_THR
CNT_W, 16, width of per-source packet counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
arb_mode  in  2  0=host only, 1=loopback only, 2=round-robin, 3=loopback priority
hst_data  in  64  host FIFO head qword (show-ahead)
hst_empty  in  1  host FIFO empty
hst_rd  out  1  host FIFO pop
lpb_data  in  64  loopback FIFO head qword (show-ahead)
lpb_empty  in  1  loopback FIFO empty
lpb_rd  out  1  loopback FIFO pop
tx_mac_wr  out  1  TX MAC FIFO write (registered)
tx_mac_data  out  64  TX MAC FIFO write data (registered)
tx_mac_full  in  1  TX MAC FIFO full
tx_mac_usedw  in  13  TX MAC FIFO used words
arb_busy  out  1  packet transfer in progress (not IDLE)
arb_src  out  1  source of current/last packet: 0=host, 1=loopback
hst_pkt_cnt  out  CNT_W  host packets forwarded, wraps
lpb_pkt_cnt  out  CNT_W  loopback packets forwarded, wraps

Behaviour:
- Reset values: all outputs 0. State goes to IDLE. RR pointer points at host. qw_cnt is 0. Reset during a transfer aborts the packet with no further pops or writes; cleanup of the downstream partial packet is outside this block.
- The pop signals hst_rd/lpb_rd are combinational from state, the selected source's empty, and tx_mac_full.
- tx_mac_wr and tx_mac_data are registered from the popped qword. Latency from pop to write is 1 cycle. tx_mac_wr is high exactly one cycle per popped qword.
- Pop condition (HDR and DATA states): the selected source's empty=0 and tx_mac_full=0. Only the selected source is ever popped.
- States (one-hot): IDLE, HDR, DATA, GAP.
- IDLE → HDR when all of the following hold; latch the selected source into arb_src at the same time:
  - tx_mac_full=0;
  - tx_mac_usedw <= USEDW_THR;
  - an eligible source is non-empty.
- Source eligibility per arb_mode:
  - mode 0: host only.
  - mode 1: loopback only.
  - mode 2: if both are non-empty, grant the source the RR pointer names; otherwise grant whichever is non-empty.
  - mode 3: grant loopback if it is non-empty, else host.
- arb_mode is sampled only in IDLE. A change mid-packet takes effect on the next packet.
- HDR: on pop, forward the header unchanged. Load qw_cnt = (bcnt+7)>>3, computed with a 17-bit sum and kept as 14 bits. Increment the per-source packet counter.
  - qw_cnt=0 (bcnt=0) → GAP.
  - otherwise → DATA.
  - If the pop condition is false, stay in HDR.
- DATA: on pop, forward the qword and decrement qw_cnt. On the pop with qw_cnt==1, go to GAP.
  - Source empty or tx_mac_full → stall: no pop, no write, stay in DATA, no timeout.
- GAP: one cycle with no pop. In mode 2, the RR pointer moves to the source not just served. In all modes → IDLE.
- Because writes are registered, the last write can land in the GAP cycle. tx_mac_full is sampled at pop time; the TX FIFO must have at least 1 word of slack, which USEDW_THR guarantees.
- arb_busy = !IDLE.
- Packet counters wrap at 2^CNT_W with no saturation.
- Bytes inside data qwords are never modified.

Decomposition:
- Shared package lmac_pkg:
  - state encodings (IDLE=4'h1, HDR=4'h2, DATA=4'h4, GAP=4'h8);
  - arb_mode constants (MODE_HOST, MODE_LPBK, MODE_RR, MODE_LPRI);
  - header field position BCNT_MSB=15 / BCNT_LSB=0.
- One natural sub-module: lpbk_tx_arb_sel, the combinational grant logic. Inputs: mode, both empties, RR pointer. Outputs: grant_valid, grant_src.
- The FSM, qw counter and output registers stay in the top level.

Test Plan:
- Mode 2, both FIFOs preloaded with 2 packets of bcnt=16 (1 hdr+2 data each), full=0, usedw=0 → write order H,L,H,L. Each packet is 3 consecutive tx_mac_wr cycles followed by at least 2 idle cycles. hst_pkt_cnt=lpb_pkt_cnt=2.
- Mode 3, host non-empty, loopback packet (bcnt=60) arrives mid host packet → host packet completes intact. Then loopback is granted: 1 hdr + 8 data writes. arb_src=1.
- Loopback packet bcnt=20 (3 data qwords); raise tx_mac_full for 4 cycles after the 2nd data pop → no pops or writes during those cycles. Transfer resumes and the 4 qwords are written in order, unmodified.
- usedw=13'h301 with both sources non-empty → no grant, arb_busy=0. Drop usedw to 13'h300 → HDR entered the next cycle.
- bcnt=0 header, mode 1 → single tx_mac_wr of the header. The FSM goes HDR→GAP→IDLE and lpb_pkt_cnt increments.
- Assert reset during DATA with qw_cnt=5 → next cycle all outputs are 0 and the state is IDLE. Counters are cleared and there are no further pops.
